// File: rtl/perceptron_trainer_if.sv
// Host-side bundle for perceptron_trainer: sample loading, run control, status and weight vector.
// The host drives through the master modport and the trainer uses the slave modport.
interface perceptron_trainer_if #(
    parameter int WIDTH     = 16,
    parameter int N_IN      = 2,
    parameter int N_SAMP    = 4,
    parameter int MAX_EPOCH = 64
);
    localparam int AW = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
    localparam int EW = $clog2(MAX_EPOCH + 1);

    logic                        load_we;
    logic [AW-1:0]               load_addr;
    logic [N_IN*WIDTH-1:0]       load_x;
    logic                        load_d;
    logic [WIDTH-1:0]            u;
    logic [(N_IN+1)*WIDTH-1:0]   w_init;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        converged;
    logic [EW-1:0]               epoch_count;
    logic [(N_IN+1)*WIDTH-1:0]   w_out;

    modport master (
        output load_we, load_addr, load_x, load_d, u, w_init, start,
        input  busy, done, converged, epoch_count, w_out
    );

    modport slave (
        input  load_we, load_addr, load_x, load_d, u, w_init, start,
        output busy, done, converged, epoch_count, w_out
    );
endinterface

// File: rtl/perceptron_trainer.sv
// Multi-epoch perceptron trainer: one MAC per weight per sample, step activation, saturating
// parallel weight update, repeating epochs until an error-free epoch or the epoch limit.
module perceptron_trainer #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 10,
    parameter int N_IN      = 2,
    parameter int N_SAMP    = 4,
    parameter int MAX_EPOCH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    perceptron_trainer_if.slave  bus
);
    localparam int AW   = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
    localparam int EW   = $clog2(MAX_EPOCH + 1);
    localparam int KW   = $clog2(N_IN + 1);
    localparam int CW   = $clog2(N_SAMP + 1);
    localparam int ACCW = 2*WIDTH + $clog2(N_IN + 1);
    localparam int SW   = 2*WIDTH + 1;

    localparam logic signed [WIDTH-1:0] ONE    = WIDTH'(1 << FRAC);
    localparam logic signed [SW-1:0]    SAT_HI = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]    SAT_LO = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MAC, UPD, EPOCH_END, DONE} state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] w_q [N_IN+1];
    logic signed [WIDTH-1:0] w_upd [N_IN+1];
    logic signed [WIDTH-1:0] u_q;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [KW-1:0]           k_q;
    logic [AW-1:0]           samp_q;
    logic [CW-1:0]           err_q;
    logic [EW-1:0]           epoch_q;
    logic                    conv_q;

    logic [N_IN*WIDTH-1:0]   mem_x [N_SAMP];
    logic [N_SAMP-1:0]       mem_d;

    logic signed [WIDTH-1:0]   x_cur, w_cur;
    logic signed [2*WIDTH-1:0] prod;
    logic                      y, miss, last_samp, last_k;

    // One step of w += sgn*((u*x) >>> FRAC), widened so the sum cannot wrap before clamping.
    function automatic logic signed [WIDTH-1:0] step_w(input logic signed [WIDTH-1:0] w,
                                                       input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] uu,
                                                       input logic                    inc);
        logic signed [2*WIDTH-1:0] p;
        logic signed [SW-1:0]      s;
        p = uu * x;
        p = p >>> FRAC;
        s = {{(WIDTH+1){w[WIDTH-1]}}, w};
        if (inc) s = s + {p[2*WIDTH-1], p};
        else     s = s - {p[2*WIDTH-1], p};
        if (s > SAT_HI)      step_w = SAT_HI[WIDTH-1:0];
        else if (s < SAT_LO) step_w = SAT_LO[WIDTH-1:0];
        else                 step_w = s[WIDTH-1:0];
    endfunction

    // Operand select for the current MAC step; k=0 is the implicit bias input of 1.0.
    // NOTE: every combinational output gets a default before any conditional assignment so no latch is inferred.
    always_comb begin
        x_cur = ONE;
        w_cur = w_q[0];
        for (int k = 1; k <= N_IN; k++) begin
            if (k_q == KW'(k)) begin
                x_cur = $signed(mem_x[samp_q][(k-1)*WIDTH +: WIDTH]);
                w_cur = w_q[k];
            end
        end
    end

    assign prod      = w_cur * x_cur;
    assign acc_d     = ((k_q == '0) ? '0 : acc_q) + {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign y         = ~acc_q[ACCW-1];
    assign miss      = (y != mem_d[samp_q]);
    assign last_samp = (samp_q == AW'(N_SAMP - 1));
    assign last_k    = (k_q == KW'(N_IN));

    always_comb begin
        w_upd[0] = step_w(w_q[0], ONE, u_q, mem_d[samp_q]);
        for (int k = 1; k <= N_IN; k++)
            w_upd[k] = step_w(w_q[k], $signed(mem_x[samp_q][(k-1)*WIDTH +: WIDTH]), u_q, mem_d[samp_q]);
    end

    // NOTE: the sample store has no reset; its contents are undefined until loaded, so no reset network is spent on it.
    always_ff @(posedge clk) begin
        if (bus.load_we && !bus.busy && (int'(bus.load_addr) < N_SAMP)) begin
            mem_x[bus.load_addr] <= bus.load_x;
            mem_d[bus.load_addr] <= bus.load_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (bus.start) state_d = MAC;
            MAC:        if (last_k) state_d = UPD;
            UPD:        state_d = last_samp ? EPOCH_END : MAC;
            EPOCH_END: begin
                if (err_q == '0 || epoch_q == EW'(MAX_EPOCH - 1)) state_d = DONE;
                else                                              state_d = MAC;
            end
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == MAC) || (state_q == UPD) || (state_q == EPOCH_END);
        bus.done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= N_IN; k++) w_q[k] <= '0;
            u_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            samp_q  <= '0;
            err_q   <= '0;
            epoch_q <= '0;
            conv_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int k = 0; k <= N_IN; k++) w_q[k] <= bus.w_init[k*WIDTH +: WIDTH];
                        u_q     <= bus.u;
                        k_q     <= '0;
                        samp_q  <= '0;
                        err_q   <= '0;
                        epoch_q <= '0;
                        conv_q  <= 1'b0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= last_k ? '0 : k_q + 1'b1;
                end
                UPD: begin
                    if (miss) begin
                        for (int k = 0; k <= N_IN; k++) w_q[k] <= w_upd[k];
                        err_q <= err_q + 1'b1;
                    end
                    samp_q <= last_samp ? '0 : samp_q + 1'b1;
                end
                EPOCH_END: begin
                    epoch_q <= epoch_q + 1'b1;
                    if (err_q == '0)                         conv_q <= 1'b1;
                    else if (epoch_q != EW'(MAX_EPOCH - 1))  err_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.converged   = conv_q;
    assign bus.epoch_count = epoch_q;

    always_comb begin
        bus.w_out = '0;
        for (int k = 0; k <= N_IN; k++) bus.w_out[k*WIDTH +: WIDTH] = w_q[k];
    end
endmodule
